// File: rtl/seg_scan_pkg.sv
// ============================================================================
// Module   : seg_scan_pkg
// Purpose  : Shared constants and types for the 7-segment scan decoder:
//            segment patterns for digits 0-9, slot select codes, special
//            output codes and the slot FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_scan_pkg;

    // Segment patterns, bit0=a .. bit6=g, bit7=dp (active-high)
    localparam logic [7:0] SEG_0 = 8'h3F;
    localparam logic [7:0] SEG_1 = 8'h06;
    localparam logic [7:0] SEG_2 = 8'h5B;
    localparam logic [7:0] SEG_3 = 8'h4F;
    localparam logic [7:0] SEG_4 = 8'h66;
    localparam logic [7:0] SEG_5 = 8'h6D;
    localparam logic [7:0] SEG_6 = 8'h7D;
    localparam logic [7:0] SEG_7 = 8'h07;
    localparam logic [7:0] SEG_8 = 8'h7F;
    localparam logic [7:0] SEG_9 = 8'h6F;

    // Active-low digit select codes
    localparam logic [7:0] CAT_UNITS = 8'hFE;
    localparam logic [7:0] CAT_TENS  = 8'hFD;

    // Non-numeric output codes
    localparam logic [3:0] BLANK = 4'hE;
    localparam logic [3:0] ERR   = 4'hF;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_e;

    // True when the digit-select code addresses one of the two slots
    function automatic logic is_slot(input logic [7:0] cat_code);
        return (cat_code == CAT_UNITS) || (cat_code == CAT_TENS);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_to_bcd.sv
// ============================================================================
// Module   : seg7_to_bcd
// Purpose  : Combinational 7-segment pattern to BCD decoder.
//            0x00 decodes to BLANK; any pattern outside the digit table
//            decodes to ERR and raises illegal_o.
// Ports    : pat_i     [7:0] segment pattern (bit7 = dp)
//            code_o    [3:0] BCD digit, BLANK or ERR
//            illegal_o       pattern is not a digit and not blank
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_to_bcd
    import seg_scan_pkg::*;
(
    input  logic [7:0] pat_i,
    output logic [3:0] code_o,
    output logic       illegal_o
);

    always_comb begin
        code_o    = ERR;
        illegal_o = 1'b0;
        case (pat_i)
            SEG_0:   code_o = 4'd0;
            SEG_1:   code_o = 4'd1;
            SEG_2:   code_o = 4'd2;
            SEG_3:   code_o = 4'd3;
            SEG_4:   code_o = 4'd4;
            SEG_5:   code_o = 4'd5;
            SEG_6:   code_o = 4'd6;
            SEG_7:   code_o = 4'd7;
            SEG_8:   code_o = 4'd8;
            SEG_9:   code_o = 4'd9;
            8'h00:   code_o = BLANK;
            default: begin
                code_o    = ERR;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg_scan_decoder.sv
// ============================================================================
// Module   : seg_scan_decoder
// Purpose  : Monitors a multiplexed two-digit 7-segment bus, waits for each
//            scan slot to settle, decodes it and publishes {tens,units}
//            frames with change/zero/blank/error/stale status.
// Ports    : clk, rst (async, active-high)
//            cat [7:0]  digit select, active-low (FE = units, FD = tens)
//            seg [7:0]  segments, active-high, bit7 = dp
//            d1/d2 [3:0] published units/tens code
//            frame_valid, changed  one-cycle pulses on publish
//            zero, blank           levels derived from d1/d2
//            err                   sticky illegal-pattern flag
//            stale                 no cat transition for WDOG_CYC cycles
// Config   : SEG_DP_IGNORE_EN - when defined, the decimal point bit is
//            masked before decode so a lit dp is legal.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int STABLE_CYC = 4,
    parameter int WDOG_CYC   = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cat,
    input  logic [7:0] seg,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic       frame_valid,
    output logic       changed,
    output logic       zero,
    output logic       blank,
    output logic       err,
    output logic       stale
);

    localparam int              WD_W       = $clog2(WDOG_CYC + 1);
    localparam logic [3:0]      STABLE_LIM = 4'(STABLE_CYC);
    localparam logic [WD_W-1:0] WDOG_LIM   = WD_W'(WDOG_CYC);

    // Registered inputs and their one-cycle-older copies
    logic [7:0]      cat_q, seg_q, cat_p_q, seg_p_q;
    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [1:0]      cap_q, cap_d;          // bit0 = units, bit1 = tens
    logic [3:0]      units_q, units_d, tens_q, tens_d;
    logic [3:0]      d1_q, d1_d, d2_q, d2_d;
    logic            fv_q, fv_d, chg_q, chg_d;
    logic            err_q, err_d;
    logic            pub_q, pub_d;          // at least one frame published
    logic [WD_W-1:0] wd_q, wd_d;

    logic       cat_chg, seg_chg, capture, is_units, publish;
    logic [1:0] mask_new;
    logic [7:0] dec_in;
    logic [3:0] dec_code;
    logic       dec_ill;

    assign cat_chg = (cat_q != cat_p_q);
    assign seg_chg = (seg_q != seg_p_q);

`ifdef SEG_DP_IGNORE_EN
    assign dec_in = {1'b0, seg_q[6:0]};
`else
    assign dec_in = seg_q;
`endif

    // Decodes the value being captured; the slot registers hold codes.
    seg7_to_bcd u_dec (
        .pat_i     (dec_in),
        .code_o    (dec_code),
        .illegal_o (dec_ill)
    );

    // Slot FSM. A change always wins over reaching the stable count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            SYNC: begin
                if (is_slot(cat_q)) begin
                    state_d = SETTLE;
                    cnt_d   = 4'd1;
                end
            end
            SETTLE: begin
                if (cat_chg || seg_chg) begin
                    if (is_slot(cat_q)) begin
                        cnt_d = 4'd1;
                    end else begin
                        state_d = SYNC;
                        cnt_d   = 4'd0;
                    end
                end else if ((cnt_q + 4'd1) >= STABLE_LIM) begin
                    capture = 1'b1;
                    state_d = HOLD;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HOLD: begin
                if (cat_chg) begin
                    if (is_slot(cat_q)) begin
                        state_d = SETTLE;
                        cnt_d   = 4'd1;
                    end else begin
                        state_d = SYNC;
                        cnt_d   = 4'd0;
                    end
                end
            end
            default: begin
                state_d = SYNC;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Frame assembly, flags and watchdog
    always_comb begin
        is_units = (cat_q == CAT_UNITS);
        mask_new = cap_q | (is_units ? 2'b01 : 2'b10);
        units_d  = (capture && is_units)  ? dec_code : units_q;
        tens_d   = (capture && !is_units) ? dec_code : tens_q;
        publish  = capture && (mask_new == 2'b11);
        cap_d    = cap_q;
        d1_d     = d1_q;
        d2_d     = d2_q;
        fv_d     = 1'b0;
        chg_d    = 1'b0;
        pub_d    = pub_q;
        if (capture) begin
            cap_d = publish ? 2'b00 : mask_new;
        end
        if (publish) begin
            d1_d  = units_d;
            d2_d  = tens_d;
            fv_d  = 1'b1;
            chg_d = !pub_q || ({tens_d, units_d} != {d2_q, d1_q});
            pub_d = 1'b1;
        end
        err_d = err_q | (capture & dec_ill);
        wd_d  = wd_q;
        if (cat_chg) begin
            wd_d = '0;
        end else if (wd_q != WDOG_LIM) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cat_q   <= 8'hFF;
            seg_q   <= 8'h00;
            cat_p_q <= 8'hFF;
            seg_p_q <= 8'h00;
            state_q <= SYNC;
            cnt_q   <= 4'd0;
            cap_q   <= 2'b00;
            units_q <= BLANK;
            tens_q  <= BLANK;
            d1_q    <= BLANK;
            d2_q    <= BLANK;
            fv_q    <= 1'b0;
            chg_q   <= 1'b0;
            err_q   <= 1'b0;
            pub_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            cat_q   <= cat;
            seg_q   <= seg;
            cat_p_q <= cat_q;
            seg_p_q <= seg_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            units_q <= units_d;
            tens_q  <= tens_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            fv_q    <= fv_d;
            chg_q   <= chg_d;
            err_q   <= err_d;
            pub_q   <= pub_d;
            wd_q    <= wd_d;
        end
    end

    assign d1          = d1_q;
    assign d2          = d2_q;
    assign frame_valid = fv_q;
    assign changed     = chg_q;
    assign err         = err_q;
    assign stale       = (wd_q == WDOG_LIM);
    // Derived from the published digits, so blank reads 1 while both are BLANK after reset
    assign zero        = (d1_q == 4'd0) && (d2_q == 4'd0);
    assign blank       = (d1_q == BLANK) || (d2_q == BLANK);

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
// ============================================================================
// Module   : tb_seg_scan_decoder
// Purpose  : Self-checking bench for seg_scan_decoder. Stimulus is a list of
//            (cat, seg, cycles) runs; a run-level model predicts captures,
//            published frames and the sticky error flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_decoder;

    localparam int STABLE = 4;
    localparam int WDOG   = 4096;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cat, seg;
    logic [3:0] d1, d2;
    logic       frame_valid, changed, zero, blank, err, stale;

    always #5 clk = ~clk;

    seg_scan_decoder #(.STABLE_CYC(STABLE), .WDOG_CYC(WDOG)) dut (
        .clk(clk), .rst(rst), .cat(cat), .seg(seg),
        .d1(d1), .d2(d2), .frame_valid(frame_valid), .changed(changed),
        .zero(zero), .blank(blank), .err(err), .stale(stale)
    );

    typedef struct packed {
        logic [7:0] c;
        logic [7:0] s;
        int         n;
    } item_t;

    item_t       items[$];
    logic [10:0] exp_q[$];   // {changed, d2, d1, zero, blank}
    logic [10:0] obs_q[$];
    logic [7:0]  pats[10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                              8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    int tests_run = 0;
    int tests_failed = 0;

    // Run-level model state
    logic [7:0] m_cat, m_seg;
    int         m_run;
    bit         m_done, m_pub, m_err;
    logic [1:0] m_mask;
    logic [3:0] m_units, m_tens, m_d1, m_d2;

    always @(negedge clk)
        if (frame_valid === 1'b1) obs_q.push_back({changed, d2, d1, zero, blank});

    function automatic logic [4:0] ref_decode(input logic [7:0] s_in);
        logic [7:0] s;
        s = s_in;
`ifdef SEG_DP_IGNORE_EN
        s[7] = 1'b0;
`endif
        if (s == 8'h00) return {1'b0, 4'hE};
        for (int i = 0; i < 10; i++)
            if (pats[i] == s) return {1'b0, 4'(i)};
        return {1'b1, 4'hF};
    endfunction

    task automatic model_reset();
        m_cat = 8'hFF; m_seg = 8'h00; m_run = 0; m_done = 0;
        m_pub = 0; m_err = 0; m_mask = 2'b00;
        m_units = 4'hE; m_tens = 4'hE; m_d1 = 4'hE; m_d2 = 4'hE;
    endtask

    // A visit is a run of constant cat; the first seg run inside it that
    // lasts STABLE cycles is captured, later seg changes are ignored.
    task automatic model_item(input logic [7:0] c, input logic [7:0] s, input int n);
        logic [4:0] r;
        logic       chg;
        if (c != m_cat) begin
            m_cat = c; m_seg = s; m_run = 0; m_done = 0;
        end else if (s != m_seg) begin
            m_seg = s; m_run = 0;
        end
        if ((c == 8'hFE || c == 8'hFD) && !m_done) begin
            m_run += n;
            if (m_run >= STABLE) begin
                m_done = 1;
                r = ref_decode(s);
                if (r[4]) m_err = 1;
                if (c == 8'hFE) begin m_units = r[3:0]; m_mask[0] = 1'b1; end
                else            begin m_tens  = r[3:0]; m_mask[1] = 1'b1; end
                if (m_mask == 2'b11) begin
                    chg = !m_pub || ({m_tens, m_units} != {m_d2, m_d1});
                    m_d1 = m_units; m_d2 = m_tens; m_pub = 1; m_mask = 2'b00;
                    exp_q.push_back({chg, m_d2, m_d1,
                                     (m_d1 == 4'd0 && m_d2 == 4'd0),
                                     (m_d1 == 4'hE || m_d2 == 4'hE)});
                end
            end
        end
    endtask

    task automatic add(input logic [7:0] c, input logic [7:0] s, input int n);
        items.push_back('{c: c, s: s, n: n});
    endtask

    task automatic play();
        add(8'hFF, 8'h00, 10);
        foreach (items[i]) begin
            model_item(items[i].c, items[i].s, items[i].n);
            cat = items[i].c;
            seg = items[i].s;
            repeat (items[i].n) @(negedge clk);
        end
        items.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; cat = 8'hFF; seg = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        tests_run++;
        if ({d1, d2, frame_valid, changed, zero, blank, err, stale} !== {4'hE, 4'hE, 6'b000100}) begin
            tests_failed++;
            $display("FAIL reset: got d1=%h d2=%h fv=%b chg=%b zero=%b blank=%b err=%b stale=%b, expected E E 0 0 0 1 0 0",
                     d1, d2, frame_valid, changed, zero, blank, err, stale);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        add(8'hFE, 8'h5B, 10); add(8'hFD, 8'h06, 10);
        play();
        tests_run++;
        if (d1 !== 4'd2 || d2 !== 4'd1 || zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_digits: got d1=%h d2=%h zero=%b, expected 2 1 0", d1, d2, zero);
        end
        add(8'hFE, 8'h5B, 10); add(8'hFD, 8'h06, 10);
        play();
        add(8'hFE, 8'h3F, 10); add(8'hFD, 8'h3F, 10);
        play();
        tests_run++;
        if (zero !== 1'b1 || blank !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_zero: got zero=%b blank=%b, expected 1 0", zero, blank);
        end
        add(8'hFE, 8'h00, 10); add(8'hFD, 8'h3F, 10);
        play();
        tests_run++;
        if (d1 !== 4'hE || blank !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_blank: got d1=%h blank=%b, expected E 1", d1, blank);
        end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL basic_count: got %0d frames, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL basic_frame%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 10; i++) add(8'hFE, (i % 2) ? 8'h06 : 8'h5B, 2);
        add(8'hFD, 8'h4F, 8);          // tens alone must not publish
        play();
        tests_run++;
        if (obs_q.size() != 0) begin
            tests_failed++;
            $display("FAIL glitch_nocap: got %0d frames, expected 0", obs_q.size());
        end
        add(8'hFE, 8'h07, 8); add(8'hFD, 8'h66, 8);
        play();
        tests_run++;
        if (d1 !== 4'd7) begin
            tests_failed++;
            $display("FAIL glitch_d1: got %h, expected 7", d1);
        end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL glitch_count: got %0d frames, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL glitch_frame%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_err();
`ifdef SEG_DP_IGNORE_EN
        add(8'hFE, 8'hBF, 8); add(8'hFD, 8'h06, 8);
        play();
        tests_run++;
        if (err !== 1'b0 || d1 !== 4'd0) begin
            tests_failed++;
            $display("FAIL err_dp: got err=%b d1=%h, expected 0 0", err, d1);
        end
`endif
        add(8'hFE, 8'h55, 8); add(8'hFD, 8'h06, 8);
        add(8'hFE, 8'h6D, 8); add(8'hFD, 8'h7F, 8);
        play();
        tests_run++;
        if (err !== m_err || err !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_sticky: got %b, expected 1", err);
        end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL err_count: got %0d frames, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL err_frame%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    // Slot lengths at and just below the stable threshold, switching directly
    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            add(8'hFE, pats[i % 10], (i % 3 == 0) ? STABLE - 1 : STABLE);
            add(8'hFD, pats[(i + 3) % 10], (i % 4 == 1) ? STABLE - 1 : STABLE);
        end
        play();
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d frames, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL b2b_frame%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        int r, r2;
        logic [7:0] c, s;
        for (int i = 0; i < 250; i++) begin
            r  = $urandom_range(0, 9);
            r2 = $urandom_range(0, 19);
            c  = (r < 4) ? 8'hFE : (r < 8) ? 8'hFD : (r < 9) ? 8'hFF : 8'hF7;
            s  = (r2 < 16) ? pats[r2 % 10] : (r2 < 18) ? 8'h00 : 8'($urandom);
            add(c, s, $urandom_range(1, 9));
        end
        play();
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL rand_count: got %0d frames, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL rand_frame%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if (err !== m_err) begin
            tests_failed++;
            $display("FAIL rand_err: got %b, expected %b", err, m_err);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_watchdog();
        model_item(8'hFE, 8'h3F, WDOG + 4);
        cat = 8'hFE; seg = 8'h3F;
        repeat (WDOG - 6) @(negedge clk);
        tests_run++;
        if (stale !== 1'b0) begin
            tests_failed++;
            $display("FAIL wdog_early: got stale=%b, expected 0", stale);
        end
        repeat (10) @(negedge clk);
        tests_run++;
        if (stale !== 1'b1) begin
            tests_failed++;
            $display("FAIL wdog_stale: got stale=%b, expected 1", stale);
        end
        model_item(8'hFD, 8'h06, 2);
        cat = 8'hFD; seg = 8'h06;
        repeat (2) @(negedge clk);
        tests_run++;
        if (stale !== 1'b0) begin
            tests_failed++;
            $display("FAIL wdog_clear: got stale=%b, expected 0", stale);
        end
        add(8'hFD, 8'h06, 8);
        play();
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL wdog_count: got %0d frames, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL wdog_frame%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        // Capture units, then reset while the tens slot is settling
        add(8'hFE, 8'h66, 8);
        foreach (items[i]) begin
            model_item(items[i].c, items[i].s, items[i].n);
            cat = items[i].c; seg = items[i].s;
            repeat (items[i].n) @(negedge clk);
        end
        items.delete();
        cat = 8'hFD; seg = 8'h7D;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({d1, d2, frame_valid, changed, zero, blank, err, stale} !== {4'hE, 4'hE, 6'b000100}) begin
            tests_failed++;
            $display("FAIL rst_mid: got d1=%h d2=%h fv=%b chg=%b zero=%b blank=%b err=%b stale=%b, expected E E 0 0 0 1 0 0",
                     d1, d2, frame_valid, changed, zero, blank, err, stale);
        end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL rst_pre_count: got %0d frames, expected %0d", obs_q.size(), exp_q.size());
        end
        obs_q.delete(); exp_q.delete();
        @(negedge clk);
        cat = 8'hFF; seg = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        add(8'hFD, 8'h06, 8);           // partial units discarded: no publish
        play();
        tests_run++;
        if (obs_q.size() != 0) begin
            tests_failed++;
            $display("FAIL rst_discard: got %0d frames, expected 0", obs_q.size());
        end
        add(8'hFE, 8'h4F, 8);
        play();
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL rst_post_count: got %0d frames, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL rst_frame%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_err();
        test_back_to_back();
        test_random();
        test_watchdog();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
